calc_ctrl: RTL and testbench



---
 rtl/calc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_calc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven sequencer for a two-digit BCD ALU.
// Builds BCD operands from digit keystrokes and holds the ALU opcode for a
// two-cycle execute window. It captures the result and supports operator
// chaining and repeat-equals.
module calc_ctrl #(
    parameter int NDIGITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_strobe,
    input  logic [4:0]           key,
    input  logic [4*NDIGITS:0]   alu_result,
    output logic [4*NDIGITS:0]   alu_op1,
    output logic [4*NDIGITS:0]   alu_op2,
    output logic [2:0]           alu_opcode,
    output logic [4*NDIGITS:0]   disp_value,
    output logic                 busy,
    output logic                 done
);

    localparam int W = 4*NDIGITS + 1;

    typedef enum logic [2:0] {
        ENTER1 = 3'd0,
        ENTER2 = 3'd1,
        EXEC1  = 3'd2,
        EXEC2  = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   op1, op1_nx;
    logic [W-1:0]   op2, op2_nx;
    logic [W-1:0]   result, result_nx;
    logic [2:0]     pend_op, pend_op_nx;
    logic [2:0]     next_op, next_op_nx;
    logic [1:0]     count, count_nx;
    logic           op2_seen, op2_seen_nx;
    logic           eq_ret, eq_ret_nx;
    logic           done_r, done_nx;

    logic           is_digit, is_oper, is_equal, is_clear;
    logic [2:0]     key_op;
    logic           room;

    // Classify the strobed key; codes 14..31 match nothing and fall through.
    always_comb begin
        is_digit = key_strobe && (key <= 5'd9);
        is_oper  = key_strobe && ((key == 5'd10) || (key == 5'd11));
        is_equal = key_strobe && (key == 5'd12);
        is_clear = key_strobe && (key == 5'd13);
        key_op   = (key == 5'd10) ? 3'b001 : 3'b010;
        room     = (count < 2'(NDIGITS));
    end

    // Next-state and register-update logic; eq_ret=1 means return to SHOW
    // after execute, 0 means continue chaining in ENTER2 with next_op.
    always_comb begin
        state_nx    = state;
        op1_nx      = op1;
        op2_nx      = op2;
        result_nx   = result;
        pend_op_nx  = pend_op;
        next_op_nx  = next_op;
        count_nx    = count;
        op2_seen_nx = op2_seen;
        eq_ret_nx   = eq_ret;
        done_nx     = 1'b0;

        if (is_clear) begin
            state_nx    = ENTER1;
            op1_nx      = '0;
            op2_nx      = '0;
            result_nx   = '0;
            pend_op_nx  = '0;
            next_op_nx  = '0;
            count_nx    = '0;
            op2_seen_nx = 1'b0;
            eq_ret_nx   = 1'b0;
        end else begin
            case (state)
                ENTER1: begin
                    if (is_digit && room) begin
                        op1_nx   = {1'b0, op1[4*NDIGITS-5:0], key[3:0]};
                        count_nx = count + 2'd1;
                    end else if (is_oper) begin
                        pend_op_nx  = key_op;
                        op2_nx      = '0;
                        count_nx    = '0;
                        op2_seen_nx = 1'b0;
                        state_nx    = ENTER2;
                    end
                end
                ENTER2: begin
                    if (is_digit) begin
                        op2_seen_nx = 1'b1;
                        if (room) begin
                            op2_nx   = {1'b0, op2[4*NDIGITS-5:0], key[3:0]};
                            count_nx = count + 2'd1;
                        end
                    end else if (is_oper) begin
                        if (!op2_seen) begin
                            pend_op_nx = key_op;
                        end else begin
                            next_op_nx = key_op;
                            eq_ret_nx  = 1'b0;
                            state_nx   = EXEC1;
                        end
                    end else if (is_equal) begin
                        eq_ret_nx = 1'b1;
                        state_nx  = EXEC1;
                    end
                end
                EXEC1: begin
                    state_nx = EXEC2;
                end
                EXEC2: begin
                    result_nx = alu_result;
                    done_nx   = 1'b1;
                    if (eq_ret) begin
                        state_nx = SHOW;
                    end else begin
                        op1_nx      = {1'b0, alu_result[W-2:0]};
                        op2_nx      = '0;
                        count_nx    = '0;
                        op2_seen_nx = 1'b0;
                        pend_op_nx  = next_op;
                        state_nx    = ENTER2;
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        op1_nx   = {{(W-4){1'b0}}, key[3:0]};
                        count_nx = 2'd1;
                        state_nx = ENTER1;
                    end else if (is_oper) begin
                        op1_nx      = {1'b0, result[W-2:0]};
                        op2_nx      = '0;
                        count_nx    = '0;
                        op2_seen_nx = 1'b0;
                        pend_op_nx  = key_op;
                        state_nx    = ENTER2;
                    end else if (is_equal) begin
                        op1_nx    = {1'b0, result[W-2:0]};
                        eq_ret_nx = 1'b1;
                        state_nx  = EXEC1;
                    end
                end
                default: state_nx = ENTER1;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ENTER1;
            op1      <= '0;
            op2      <= '0;
            result   <= '0;
            pend_op  <= '0;
            next_op  <= '0;
            count    <= '0;
            op2_seen <= 1'b0;
            eq_ret   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            op1      <= op1_nx;
            op2      <= op2_nx;
            result   <= result_nx;
            pend_op  <= pend_op_nx;
            next_op  <= next_op_nx;
            count    <= count_nx;
            op2_seen <= op2_seen_nx;
            eq_ret   <= eq_ret_nx;
            done_r   <= done_nx;
        end
    end

    // Output decode: opcode only inside the execute window, display by state.
    always_comb begin
        alu_op1    = op1;
        alu_op2    = op2;
        done       = done_r;
        busy       = (state == EXEC1) || (state == EXEC2);
        alu_opcode = busy ? pend_op : 3'b000;
        case (state)
            ENTER2:  disp_value = op2_seen ? op2 : op1;
            SHOW:    disp_value = result;
            default: disp_value = op1;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed testbench for calc_ctrl with a behavioural BCD ALU.
module tb_calc_ctrl;

    logic       tb_clk;
    logic       rst;
    logic       key_strobe;
    logic [4:0] key;
    logic [8:0] alu_result;
    logic [8:0] alu_op1;
    logic [8:0] alu_op2;
    logic [2:0] alu_opcode;
    logic [8:0] disp_value;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    calc_ctrl #(.NDIGITS(2)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .key_strobe (key_strobe),
        .key        (key),
        .alu_result (alu_result),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opcode (alu_opcode),
        .disp_value (disp_value),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Behavioural two-digit BCD ALU: add with carry, subtract with borrow
    int a_val, b_val;
    always_comb begin
        a_val = int'(alu_op1[7:4]) * 10 + int'(alu_op1[3:0]);
        b_val = int'(alu_op2[7:4]) * 10 + int'(alu_op2[3:0]);
        case (alu_opcode)
            3'b001:  alu_result = {(a_val + b_val) >= 100, to_bcd((a_val + b_val) % 100)};
            3'b010:  alu_result = (a_val >= b_val) ? {1'b0, to_bcd(a_val - b_val)}
                                                   : {1'b1, to_bcd(a_val + 100 - b_val)};
            default: alu_result = 9'h000;
        endcase
    end

    // Strobe one key at the current negedge; returns one negedge later
    task automatic press(input logic [4:0] k);
        key_strobe = 1'b1;
        key        = k;
        @(negedge tb_clk);
        key_strobe = 1'b0;
        key        = 5'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_strobe = 1'b0;
        key = 5'd0;
        repeat (2) @(negedge tb_clk);
        rst = 1'b0;
        checks++;
        if ({alu_op1, alu_op2, alu_opcode, disp_value, busy, done} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got op1=%h op2=%h opc=%b disp=%h busy=%b done=%b expected all 0",
                     alu_op1, alu_op2, alu_opcode, disp_value, busy, done);
        end
    endtask

    task automatic test_add;
        press(5'd13);
        press(5'd3); press(5'd7); press(5'd10);
        checks++;
        if (disp_value !== 9'h037) begin
            errors++; $display("[TB] FAIL add_disp_op1 got %h expected 037", disp_value);
        end
        press(5'd1); press(5'd2);
        checks++;
        if (disp_value !== 9'h012) begin
            errors++; $display("[TB] FAIL add_disp_op2 got %h expected 012", disp_value);
        end
        press(5'd12);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (busy !== 1'b1 || alu_opcode !== 3'b001 || alu_op1 !== 9'h037 ||
                alu_op2 !== 9'h012 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL add_exec_cycle%0d got busy=%b opc=%b op1=%h op2=%h done=%b expected 1 001 037 012 0",
                         c, busy, alu_opcode, alu_op1, alu_op2, done);
            end
            @(negedge tb_clk);
        end
        checks++;
        if (busy !== 1'b0 || alu_opcode !== 3'b000 || done !== 1'b1 || disp_value !== 9'h049) begin
            errors++;
            $display("[TB] FAIL add_capture got busy=%b opc=%b done=%b disp=%h expected 0 000 1 049",
                     busy, alu_opcode, done, disp_value);
        end
        @(negedge tb_clk);
        checks++;
        if (done !== 1'b0 || disp_value !== 9'h049) begin
            errors++; $display("[TB] FAIL add_done_pulse got done=%b disp=%h expected 0 049", done, disp_value);
        end
    endtask

    task automatic test_arith;
        logic [4:0] seq [3][5];
        logic [8:0] exp [3];
        seq = '{'{5'd8, 5'd6, 5'd11, 5'd5, 5'd5},
                '{5'd2, 5'd1, 5'd11, 5'd3, 5'd3},
                '{5'd8, 5'd1, 5'd10, 5'd8, 5'd1}};
        exp = '{9'h031, 9'h188, 9'h162};
        for (int v = 0; v < 3; v++) begin
            press(5'd13);
            for (int i = 0; i < 5; i++) press(seq[v][i]);
            press(5'd12);
            repeat (2) @(negedge tb_clk);
            checks++;
            if (disp_value !== exp[v] || done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL arith_vec%0d got disp=%h done=%b expected %h 1", v, disp_value, done, exp[v]);
            end
        end
    endtask

    task automatic test_chain;
        press(5'd13);
        press(5'd1); press(5'd5); press(5'd10); press(5'd0); press(5'd5);
        press(5'd10);
        repeat (2) @(negedge tb_clk);
        checks++;
        if (done !== 1'b1 || disp_value !== 9'h020 || busy !== 1'b0 ||
            alu_op1 !== 9'h020 || alu_op2 !== 9'h000) begin
            errors++;
            $display("[TB] FAIL chain_intermediate got done=%b disp=%h busy=%b op1=%h op2=%h expected 1 020 0 020 000",
                     done, disp_value, busy, alu_op1, alu_op2);
        end
        press(5'd1); press(5'd0); press(5'd12);
        checks++;
        if (alu_opcode !== 3'b001) begin
            errors++; $display("[TB] FAIL chain_opcode got %b expected 001", alu_opcode);
        end
        repeat (2) @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h030 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL chain_final got disp=%h done=%b expected 030 1", disp_value, done);
        end
        press(5'd12);
        repeat (2) @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h040 || alu_op2 !== 9'h010 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chain_repeat got disp=%h op2=%h done=%b expected 040 010 1", disp_value, alu_op2, done);
        end
    endtask

    task automatic test_entry;
        press(5'd13);
        press(5'd1); press(5'd2); press(5'd3);
        checks++;
        if (alu_op1 !== 9'h012 || disp_value !== 9'h012) begin
            errors++; $display("[TB] FAIL entry_third_digit got op1=%h disp=%h expected 012 012", alu_op1, disp_value);
        end
        press(5'd10);
        press(5'd11);
        checks++;
        if (busy !== 1'b0 || disp_value !== 9'h012) begin
            errors++; $display("[TB] FAIL entry_op_replace got busy=%b disp=%h expected 0 012", busy, disp_value);
        end
        press(5'd4);
        checks++;
        if (disp_value !== 9'h004) begin
            errors++; $display("[TB] FAIL entry_op2_disp got %h expected 004", disp_value);
        end
        press(5'd12);
        checks++;
        if (alu_opcode !== 3'b010 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL entry_pend_op got opc=%b busy=%b expected 010 1", alu_opcode, busy);
        end
        repeat (2) @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h008) begin
            errors++; $display("[TB] FAIL entry_result got %h expected 008", disp_value);
        end
    endtask

    task automatic test_exec_drop;
        press(5'd13);
        press(5'd3); press(5'd7); press(5'd10); press(5'd1); press(5'd2);
        press(5'd12);
        press(5'd5);
        checks++;
        if (busy !== 1'b1 || alu_opcode !== 3'b001 || alu_op1 !== 9'h037) begin
            errors++;
            $display("[TB] FAIL drop_digit got busy=%b opc=%b op1=%h expected 1 001 037", busy, alu_opcode, alu_op1);
        end
        @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h049 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL drop_digit_result got disp=%h done=%b expected 049 1", disp_value, done);
        end
        press(5'd12);
        press(5'd10);
        checks++;
        if (busy !== 1'b1 || alu_opcode !== 3'b001) begin
            errors++; $display("[TB] FAIL drop_oper got busy=%b opc=%b expected 1 001", busy, alu_opcode);
        end
        @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h061 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL drop_oper_result got disp=%h done=%b expected 061 1", disp_value, done);
        end
        press(5'd12);
        @(negedge tb_clk);
        press(5'd13);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({alu_op1, alu_op2, alu_opcode, disp_value, busy, done} !== 32'h0) begin
                errors++;
                $display("[TB] FAIL clear_in_exec2_c%0d got op1=%h op2=%h opc=%b disp=%h busy=%b done=%b expected all 0",
                         c, alu_op1, alu_op2, alu_opcode, disp_value, busy, done);
            end
            @(negedge tb_clk);
        end
        press(5'd2);
        checks++;
        if (disp_value !== 9'h002) begin
            errors++; $display("[TB] FAIL clear_then_digit got %h expected 002", disp_value);
        end
    endtask

    task automatic test_rst_mid;
        press(5'd13);
        press(5'd3); press(5'd7);
        press(5'd15);
        checks++;
        if (alu_op1 !== 9'h037 || disp_value !== 9'h037 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignored_code got op1=%h disp=%h busy=%b expected 037 037 0", alu_op1, disp_value, busy);
        end
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        checks++;
        if ({alu_op1, alu_op2, alu_opcode, disp_value, busy, done} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_entry got op1=%h op2=%h opc=%b disp=%h busy=%b done=%b expected all 0",
                     alu_op1, alu_op2, alu_opcode, disp_value, busy, done);
        end
        press(5'd5); press(5'd10); press(5'd12);
        repeat (2) @(negedge tb_clk);
        checks++;
        if (disp_value !== 9'h005 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_then_equal got disp=%h done=%b expected 005 1", disp_value, done);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1;
        key_strobe = 1'b0;
        key = 5'd0;
        @(negedge tb_clk);
        test_reset();
        test_add();
        test_arith();
        test_chain();
        test_entry();
        test_exec_drop();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
